// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcode bit indices, issue-FSM states and in-flight tag type
package alu_pkg;
    localparam int ALUSIG_W = 12;
    localparam int ALU_ADD = 0;
    localparam int ALU_LD  = 1;
    localparam int ALU_ST  = 2;
    localparam int ALU_SUB = 3;
    localparam int ALU_MUL = 4;
    localparam int ALU_CMP = 5;
    localparam int ALU_MOV = 6;
    localparam int ALU_OR  = 7;
    localparam int ALU_AND = 8;
    localparam int ALU_NOT = 9;
    localparam int ALU_LSL = 10;
    localparam int ALU_LSR = 11;
    typedef enum logic {IDLE, MUL_BUSY} state_t;
    typedef struct packed {
        logic        valid;
        logic        lane;
        logic [15:0] instr;
    } tag_t;
endpackage

// File: rtl/alu_tag_pipe.sv
// alu_tag_pipe: depth-N shift register carrying in-flight op tags, cleared by rst
module alu_tag_pipe
    import alu_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  tag_t din,
    output tag_t dout
);
    tag_t stage [DEPTH];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end
    assign dout = stage[DEPTH-1];
endmodule

// File: rtl/alu_issue_sched.sv
// alu_issue_sched: round-robin issue of two decode lanes onto one ALU, with
// multiply back-pressure and lane/instr tagging of results for writeback.
module alu_issue_sched
    import alu_pkg::*;
#(
    parameter int ALU_LAT = 2,
    parameter int MUL_LAT = 3,
    parameter int W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [ALUSIG_W-1:0] req0_alusignals,
    input  logic [W-1:0]        req0_op1,
    input  logic [W-1:0]        req0_op2,
    input  logic [4:0]          req0_immx,
    input  logic                req0_isimm,
    input  logic [15:0]         req0_instr,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [ALUSIG_W-1:0] req1_alusignals,
    input  logic [W-1:0]        req1_op1,
    input  logic [W-1:0]        req1_op2,
    input  logic [4:0]          req1_immx,
    input  logic                req1_isimm,
    input  logic [15:0]         req1_instr,
    output logic [ALUSIG_W-1:0] alu_alusignals,
    output logic [W-1:0]        alu_op1,
    output logic [W-1:0]        alu_op2,
    output logic [4:0]          alu_immx,
    output logic                alu_isimm,
    output logic [15:0]         alu_instr,
    input  logic [W-1:0]        alu_result,
    output logic                wb_valid,
    output logic                wb_lane,
    output logic [15:0]         wb_instr,
    output logic [W-1:0]        wb_result,
    output logic [15:0]         grant0_cnt,
    output logic [15:0]         grant1_cnt
);
    state_t      state, state_nx;
    logic        prio;
    logic [7:0]  busy_cnt, busy_nx;
    logic        gnt, gmul;
    tag_t        tag_in, tag_out;

    always_comb begin
        req0_ready = !rst && state == IDLE && req0_valid && (!req1_valid || !prio);
        req1_ready = !rst && state == IDLE && req1_valid && (!req0_valid || prio);
        gnt        = req0_ready || req1_ready;
        gmul       = req1_ready ? req1_alusignals[ALU_MUL] : req0_ready && req0_alusignals[ALU_MUL];
        state_nx   = state;
        busy_nx    = busy_cnt;
        if (state == IDLE && gmul && MUL_LAT > 1) begin
            state_nx = MUL_BUSY;
            busy_nx  = 8'(MUL_LAT - 2);
        end else if (state == MUL_BUSY) begin
            state_nx = busy_cnt == 8'd0 ? IDLE : MUL_BUSY;
            busy_nx  = busy_cnt == 8'd0 ? busy_cnt : busy_cnt - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            busy_cnt       <= '0;
            prio           <= 1'b0;
            alu_alusignals <= '0;
            alu_op1        <= '0;
            alu_op2        <= '0;
            alu_immx       <= '0;
            alu_isimm      <= 1'b0;
            alu_instr      <= '0;
            grant0_cnt     <= '0;
            grant1_cnt     <= '0;
        end else begin
            state          <= state_nx;
            busy_cnt       <= busy_nx;
            alu_alusignals <= req1_ready ? req1_alusignals : req0_ready ? req0_alusignals : '0;
            grant0_cnt     <= grant0_cnt + 16'(req0_ready);
            grant1_cnt     <= grant1_cnt + 16'(req1_ready);
            if (gnt) begin
                prio      <= req0_ready;
                alu_op1   <= req1_ready ? req1_op1   : req0_op1;
                alu_op2   <= req1_ready ? req1_op2   : req0_op2;
                alu_immx  <= req1_ready ? req1_immx  : req0_immx;
                alu_isimm <= req1_ready ? req1_isimm : req0_isimm;
                alu_instr <= req1_ready ? req1_instr : req0_instr;
            end
        end
    end

    assign tag_in = '{valid: gnt, lane: req1_ready, instr: req1_ready ? req1_instr : req0_instr};

    alu_tag_pipe #(.DEPTH(ALU_LAT + 1)) u_tag_pipe (
        .clk  (clk),
        .rst  (rst),
        .din  (tag_in),
        .dout (tag_out)
    );

    assign wb_valid  = tag_out.valid;
    assign wb_lane   = tag_out.lane;
    assign wb_instr  = tag_out.instr;
    assign wb_result = alu_result;
endmodule

// File: tb/tb_alu_issue_sched.sv
// tb_alu_issue_sched: randomized and directed checks of alu_issue_sched against a
// cycle-level reference model (grant rules, mul blocking window, result queue).
module tb_alu_issue_sched;
    import alu_pkg::*;
    localparam int W = 16, ALU_LAT = 2, MUL_LAT = 3;

    typedef struct packed {
        logic [11:0]  sig;
        logic [W-1:0] op1;
        logic [W-1:0] op2;
        logic [4:0]   immx;
        logic         isimm;
        logic [15:0]  instr;
    } pay_t;
    typedef struct {
        int           due;
        int           lane;
        logic [15:0]  instr;
        logic [W-1:0] res;
    } exp_t;

    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;

    logic v [2];
    pay_t p [2];
    logic req0_ready, req1_ready, alu_isimm, wb_valid, wb_lane;
    logic [11:0] alu_alusignals;
    logic [W-1:0] alu_op1, alu_op2, alu_result, wb_result;
    logic [4:0] alu_immx;
    logic [15:0] alu_instr, wb_instr, grant0_cnt, grant1_cnt;

    alu_issue_sched #(.ALU_LAT(ALU_LAT), .MUL_LAT(MUL_LAT), .W(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v[0]), .req0_ready(req0_ready), .req0_alusignals(p[0].sig),
        .req0_op1(p[0].op1), .req0_op2(p[0].op2), .req0_immx(p[0].immx),
        .req0_isimm(p[0].isimm), .req0_instr(p[0].instr),
        .req1_valid(v[1]), .req1_ready(req1_ready), .req1_alusignals(p[1].sig),
        .req1_op1(p[1].op1), .req1_op2(p[1].op2), .req1_immx(p[1].immx),
        .req1_isimm(p[1].isimm), .req1_instr(p[1].instr),
        .alu_alusignals(alu_alusignals), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_immx(alu_immx), .alu_isimm(alu_isimm), .alu_instr(alu_instr),
        .alu_result(alu_result), .wb_valid(wb_valid), .wb_lane(wb_lane),
        .wb_instr(wb_instr), .wb_result(wb_result),
        .grant0_cnt(grant0_cnt), .grant1_cnt(grant1_cnt)
    );

    function automatic logic [W-1:0] alufn(input pay_t x);
        logic [W-1:0] b;
        b = x.isimm ? W'(x.immx) : x.op2;
        if (x.sig[ALU_ADD] || x.sig[ALU_LD] || x.sig[ALU_ST]) return x.op1 + b;
        if (x.sig[ALU_SUB] || x.sig[ALU_CMP]) return x.op1 - b;
        if (x.sig[ALU_MUL]) return x.op1 * b;
        if (x.sig[ALU_MOV]) return b;
        if (x.sig[ALU_OR])  return x.op1 | b;
        if (x.sig[ALU_AND]) return x.op1 & b;
        if (x.sig[ALU_NOT]) return ~b;
        if (x.sig[ALU_LSL]) return x.op1 << b[3:0];
        if (x.sig[ALU_LSR]) return x.op1 >> b[3:0];
        return '0;
    endfunction

    // Behavioural ALU: samples its inputs each cycle, answers ALU_LAT cycles later
    logic [W-1:0] ares [ALU_LAT];
    always @(posedge clk) begin
        ares[0] <= alufn('{alu_alusignals, alu_op1, alu_op2, alu_immx, alu_isimm, alu_instr});
        for (int i = 1; i < ALU_LAT; i++) ares[i] <= ares[i-1];
    end
    assign alu_result = ares[ALU_LAT-1];

    int cyc = 0, prio_m = 0, next_ok = 0, last_g = -1, npass = 0, ntot = 0;
    int cnt_m [2] = '{0, 0};
    pay_t last_pay = '0;
    logic [11:0] exp_sig = '0;
    exp_t q [$];

    task automatic run_cycle(input logic r);
        int g;
        exp_t e;
        rst = r;
        #1;
        g = -1;
        if (!r && cyc >= next_ok) g = (v[0] && v[1]) ? prio_m : v[0] ? 0 : v[1] ? 1 : -1;
        ntot++; if (req0_ready !== (g == 0)) $display("FAIL ready0 cyc %0d: got %b want %b", cyc, req0_ready, g == 0); else npass++;
        ntot++; if (req1_ready !== (g == 1)) $display("FAIL ready1 cyc %0d: got %b want %b", cyc, req1_ready, g == 1); else npass++;
        @(posedge clk);
        if (r) begin
            prio_m = 0; next_ok = 0; q.delete(); last_pay = '0; exp_sig = '0; cnt_m = '{0, 0};
        end else if (g >= 0) begin
            prio_m = 1 - g;
            next_ok = p[g].sig[ALU_MUL] ? cyc + MUL_LAT : cyc + 1;
            last_pay = p[g];
            exp_sig = p[g].sig;
            e.due = cyc + 1 + ALU_LAT; e.lane = g; e.instr = p[g].instr; e.res = alufn(p[g]);
            q.push_back(e);
            cnt_m[g] = (cnt_m[g] + 1) % 65536;
        end else exp_sig = '0;
        last_g = r ? -1 : g;
        cyc++;
        #1;
        ntot++; if (alu_alusignals !== exp_sig) $display("FAIL alu_sig cyc %0d: got %h want %h", cyc, alu_alusignals, exp_sig); else npass++;
        ntot++;
        if ({alu_op1, alu_op2, alu_immx, alu_isimm, alu_instr} !== {last_pay.op1, last_pay.op2, last_pay.immx, last_pay.isimm, last_pay.instr})
            $display("FAIL alu_payload cyc %0d: got %h/%h/%h/%b/%h want %h/%h/%h/%b/%h", cyc, alu_op1, alu_op2, alu_immx, alu_isimm, alu_instr,
                     last_pay.op1, last_pay.op2, last_pay.immx, last_pay.isimm, last_pay.instr);
        else npass++;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            ntot++; if (wb_valid !== 1'b1) $display("FAIL wb_valid cyc %0d: got %b want 1", cyc, wb_valid); else npass++;
            ntot++;
            if ({wb_lane, wb_instr, wb_result} !== {1'(e.lane), e.instr, e.res})
                $display("FAIL wb_data cyc %0d: got %b/%h/%h want %b/%h/%h", cyc, wb_lane, wb_instr, wb_result, 1'(e.lane), e.instr, e.res);
            else npass++;
        end else begin
            ntot++; if (wb_valid !== 1'b0) $display("FAIL wb_idle cyc %0d: got %b want 0", cyc, wb_valid); else npass++;
        end
        ntot++;
        if ({grant0_cnt, grant1_cnt} !== {16'(cnt_m[0]), 16'(cnt_m[1])})
            $display("FAIL counters cyc %0d: got %h/%h want %h/%h", cyc, grant0_cnt, grant1_cnt, 16'(cnt_m[0]), 16'(cnt_m[1]));
        else npass++;
        @(negedge clk);
    endtask

    function automatic pay_t rand_pay(input int mode);
        pay_t x;
        int idx;
        x.op1 = W'($urandom); x.op2 = W'($urandom); x.immx = 5'($urandom);
        x.isimm = 1'($urandom); x.instr = 16'($urandom);
        idx = $urandom_range(0, 10);
        if (idx >= ALU_MUL) idx++;
        x.sig = mode == 1 ? 12'(1 << ALU_MUL) : mode == 2 ? 12'h000 : mode == 3 ? 12'($urandom) : 12'(1 << idx);
        return x;
    endfunction

    task automatic idle(input int n);
        v[0] = 1'b0; v[1] = 1'b0;
        for (int i = 0; i < n; i++) run_cycle(1'b0);
    endtask

    task automatic test_reset();
        v[0] = 1'b1; v[1] = 1'b1; p[0] = rand_pay(0); p[1] = rand_pay(0);
        run_cycle(1'b1);
        run_cycle(1'b1);
        ntot++; if ({alu_alusignals, alu_op1, grant0_cnt, wb_valid} !== '0) $display("FAIL reset_state: got %h/%h/%h/%b want 0", alu_alusignals, alu_op1, grant0_cnt, wb_valid); else npass++;
        idle(0);
    endtask

    task automatic test_single_add();
        idle(3);
        v[0] = 1'b1; p[0] = '{12'h001, 16'h0003, 16'h0004, 5'd0, 1'b0, 16'h1234};
        run_cycle(1'b0);
        v[0] = 1'b0;
        ntot++; if (alu_alusignals !== 12'h001) $display("FAIL add_issue: got %h want 001", alu_alusignals); else npass++;
        run_cycle(1'b0);
        ntot++; if (alu_alusignals !== 12'h000) $display("FAIL add_bubble: got %h want 000", alu_alusignals); else npass++;
        run_cycle(1'b0);
        ntot++;
        if ({wb_valid, wb_lane, wb_result, grant0_cnt} !== {1'b1, 1'b0, 16'h0007, 16'h0001})
            $display("FAIL add_wb: got %b/%b/%h/%h want 1/0/0007/0001", wb_valid, wb_lane, wb_result, grant0_cnt);
        else npass++;
        idle(3);
    endtask

    task automatic test_back_to_back();
        logic [15:0] c0, c1;
        run_cycle(1'b1);
        c0 = grant0_cnt; c1 = grant1_cnt;
        v[0] = 1'b1; v[1] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            p[0] = rand_pay(0); p[1] = rand_pay(0);
            run_cycle(1'b0);
            ntot++; if (last_g !== k % 2) $display("FAIL alternate step %0d: got lane %0d want %0d", k, last_g, k % 2); else npass++;
        end
        ntot++;
        if ({grant0_cnt - c0, grant1_cnt - c1} !== {16'd4, 16'd4})
            $display("FAIL alternate_counts: got %0d/%0d want 4/4", grant0_cnt - c0, grant1_cnt - c1);
        else npass++;
        idle(4);
    endtask

    task automatic test_mul_block();
        run_cycle(1'b1);
        v[0] = 1'b1; p[0] = rand_pay(0);
        run_cycle(1'b0);
        idle(3);
        v[0] = 1'b1; p[0] = rand_pay(0);
        v[1] = 1'b1; p[1] = '{12'h010, 16'h0005, 16'h0006, 5'd0, 1'b0, 16'hBEEF};
        run_cycle(1'b0);
        ntot++; if (last_g !== 1) $display("FAIL mul_grant: got lane %0d want 1", last_g); else npass++;
        v[1] = 1'b0;
        for (int k = 0; k < MUL_LAT - 1; k++) begin
            #1;
            ntot++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL mul_block %0d: got %b want 00", k, {req0_ready, req1_ready}); else npass++;
            run_cycle(1'b0);
        end
        ntot++;
        if ({req0_ready, wb_valid, wb_lane, wb_result} !== {1'b1, 1'b1, 1'b1, 16'h001E})
            $display("FAIL mul_release: got %b/%b/%b/%h want 1/1/1/001e", req0_ready, wb_valid, wb_lane, wb_result);
        else npass++;
        run_cycle(1'b0);
        idle(4);
    endtask

    task automatic test_nop();
        v[0] = 1'b1; p[0] = rand_pay(2);
        run_cycle(1'b0);
        v[0] = 1'b0;
        ntot++; if (last_g !== 0 || alu_alusignals !== 12'h000) $display("FAIL nop_issue: got lane %0d sig %h want 0/000", last_g, alu_alusignals); else npass++;
        for (int k = 0; k < ALU_LAT; k++) run_cycle(1'b0);
        ntot++; if ({wb_valid, wb_result} !== {1'b1, 16'h0000}) $display("FAIL nop_wb: got %b/%h want 1/0000", wb_valid, wb_result); else npass++;
        idle(3);
    endtask

    task automatic test_reset_midflight();
        v[0] = 1'b1; p[0] = rand_pay(0);
        run_cycle(1'b0);
        v[0] = 1'b0; v[1] = 1'b1; p[1] = rand_pay(1);
        run_cycle(1'b0);
        v[0] = 1'b1; v[1] = 1'b0; p[0] = rand_pay(0);
        run_cycle(1'b1);
        rst = 1'b0; #1;
        ntot++;
        if ({req0_ready, wb_valid, grant0_cnt, grant1_cnt} !== {1'b1, 1'b0, 32'h0})
            $display("FAIL rst_mid: got %b/%b/%h/%h want 1/0/0000/0000", req0_ready, wb_valid, grant0_cnt, grant1_cnt);
        else npass++;
        run_cycle(1'b0);
        v[0] = 1'b0;
        run_cycle(1'b0);
        ntot++; if (wb_valid !== 1'b0) $display("FAIL rst_drop: got %b want 0", wb_valid); else npass++;
        idle(4);
    endtask

    task automatic test_random();
        run_cycle(1'b1);
        v[0] = 1'b0; v[1] = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < 2; i++)
                if (!v[i] || last_g == i) begin
                    int m;
                    m = $urandom_range(0, 9);
                    v[i] = $urandom_range(0, 3) != 0;
                    p[i] = rand_pay(m < 3 ? 1 : m == 3 ? 2 : m == 4 ? 3 : 0);
                end
            run_cycle(1'b0);
        end
        idle(5);
    endtask

    task automatic test_wrap();
        run_cycle(1'b1);
        v[0] = 1'b1; v[1] = 1'b0; p[0] = rand_pay(0);
        for (int k = 0; k < 65535; k++) run_cycle(1'b0);
        ntot++; if (grant0_cnt !== 16'hFFFF) $display("FAIL wrap_max: got %h want ffff", grant0_cnt); else npass++;
        run_cycle(1'b0);
        ntot++; if ({grant0_cnt, grant1_cnt} !== 32'h0) $display("FAIL wrap_zero: got %h/%h want 0000/0000", grant0_cnt, grant1_cnt); else npass++;
        idle(4);
    endtask

    initial begin
        v[0] = 1'b0; v[1] = 1'b0; p[0] = '0; p[1] = '0;
        @(negedge clk);
        test_reset();
        test_single_add();
        test_back_to_back();
        test_mul_block();
        test_nop();
        test_reset_midflight();
        test_random();
        test_wrap();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/alu_issue_sched.md
Name: alu_issue_sched

Overview:
- Issue scheduler that shares the single execute-stage ALU between the two decode lanes of the superscalar core.
- Arbitrates round-robin between two valid/ready requesters and drives the ALU operand/opcode inputs for one cycle per grant.
- Blocks further issue while a multi-cycle multiply occupies the multiplier.
- Tracks in-flight ops so each ALU result returns to writeback tagged with its originating lane and instruction.

Parameters:
ALU_LAT, 2, cycles from the ALU input cycle to result-valid cycle on alu_result
MUL_LAT, 3, total cycles the multiplier is occupied per multiply (issue cycle included); must be >= 1
W, 16, datapath width

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  lane 0 has an op
req0_ready  out  1  lane 0 op accepted this cycle
req0_alusignals  in  12  one-hot op select, bit order add,ld,st,sub,mul,cmp,mov,or,and,not,lsl,lsr (bit0..bit11)
req0_op1 / req0_op2  in  W  operands
req0_immx  in  5  immediate
req0_isimm  in  1  use immx as B
req0_instr  in  16  instruction word
req1_*  same set as req0_*, for lane 1
alu_alusignals  out  12  to ALU; zero = bubble
alu_op1 / alu_op2  out  W  to ALU
alu_immx  out  5  to ALU
alu_isimm  out  1  to ALU
alu_instr  out  16  to ALU
alu_result  in  W  from ALU
wb_valid  out  1  result valid this cycle
wb_lane  out  1  originating lane
wb_instr  out  16  originating instruction
wb_result  out  W  alu_result passthrough
grant0_cnt / grant1_cnt  out  16  per-lane grant counters, wrap at 2^16

Behaviour:
- Handshake and issue
  - A grant occurs in cycle T when reqN_valid && reqN_ready.
  - reqN_ready is combinational from the valids, state and prio. Requesters must not make valid depend on ready.
  - The granted payload is registered onto alu_* and presented for exactly cycle T+1.
  - In any cycle without a grant in the previous cycle, alu_alusignals = 0 and the other alu_* outputs hold their last value.
- Arbitration
  - 1-bit prio register, reset 0.
  - Only one lane valid: grant that lane.
  - Both lanes valid: grant lane prio.
  - After any grant, prio <= ~granted lane.
  - At most one grant per cycle; the loser holds valid, and its payload must stay stable until granted.
- FSM states
  - IDLE: grants allowed. A grant whose alusignals[4] (mul) is set, with MUL_LAT > 1, goes to MUL_BUSY with busy_cnt <= MUL_LAT-2.
  - MUL_BUSY: both ready = 0. If busy_cnt == 0 go to IDLE, else decrement busy_cnt.
  - With MUL_LAT = 1, a multiply stays in IDLE.
  - Net effect: the next grant after a mul at cycle T occurs no earlier than T+MUL_LAT.
- Opcode encoding
  - Payload passes through unchanged; no opcode decode other than bit 4.
  - alusignals == 0 is accepted as a NOP, occupies a slot, and still produces wb_valid.
  - Multi-hot alusignals is passed unchanged. The mul check uses bit 4 only.
- Result tracking
  - Shift register of depth ALU_LAT+1 carrying {valid, lane, instr}, entered at the grant cycle T.
  - wb_valid/wb_lane/wb_instr are asserted in cycle T+1+ALU_LAT, aligned with alu_result.
  - wb_result = alu_result combinationally, unqualified; consumers qualify it with wb_valid.
- Counters: grantN_cnt increments by 1 on each lane N grant and wraps from FFFF to 0000.
- Reset values (rst is sampled on posedge and overrides all other inputs that cycle):
  - state = IDLE, prio = 0, busy_cnt = 0.
  - All shift-register valid bits = 0, so in-flight results are dropped and wb_valid = 0.
  - alu_alusignals = 0, alu_op1/op2/immx/isimm/instr = 0.
  - Counters = 0, req_ready = 0 during rst.
- Reset mid-multiply: returns to IDLE the following cycle, and grants may resume in the first cycle after rst deasserts.

Decomposition:
- Shared package alu_pkg holds:
  - ALUSIG_W = 12.
  - Named bit indices ALU_ADD=0 … ALU_LSR=11, with ALU_MUL = 4.
  - The in-flight tag struct {valid, lane, instr[15:0]}.
- One natural sub-module: alu_tag_pipe, the parameterised depth-N tag shift register with synchronous clear.
- Arbiter and FSM stay in the top module.

Test Plan:
1. Only lane 0 valid with an add, op1=0x0003, op2=0x0004 at cycle 10 -> alu_alusignals=0x001 in cycle 11 only; wb_valid=1, wb_lane=0, wb_result=0x0007 in cycle 13; grant0_cnt=1.
2. Both lanes valid every cycle, non-mul ops, from cycle 5 after reset -> grants alternate 0,1,0,1; each lane is granted 4 times in 8 cycles; wb_lane sequence 0,1,0,1 starting cycle 8.
3. Lane 1 mul 0x0005*0x0006 granted at cycle 20 with lane 0 also valid -> both ready=0 in cycles 21-22; lane 0 granted at cycle 23; wb_result=0x001E with wb_lane=1 in cycle 23.
4. alusignals=0 from lane 0 -> accepted; alu_alusignals=0 in the issue cycle; wb_valid=1 with wb_result=0x0000 after ALU_LAT.
5. rst asserted one cycle after a mul grant, with two ops in flight -> no wb_valid for the in-flight ops; state IDLE; counters 0; a new grant succeeds in the first cycle after rst deasserts.
6. Drive 65536 lane-0 grants -> grant0_cnt wraps to 0x0000 while grant1_cnt stays 0x0000.
